// File: rtl/apb_slave_regfile.sv
// APB3 completer holding NUM_REGS word registers (index 0 is a read-only ID) with
// programmable wait states and PSLVERR on misaligned, out-of-range or read-only accesses.
module apb_slave_regfile #(
    parameter int unsigned      DSIZE       = 32,
    parameter int unsigned      ASIZE       = 32,
    parameter int unsigned      NUM_REGS    = 16,
    parameter logic [ASIZE-1:0] BASE_ADDR   = '0,
    parameter int unsigned      WAIT_CYCLES = 0,
    parameter logic [DSIZE-1:0] ID_VALUE    = 32'hA9B3_0001
) (
    input  logic             i_pclk,
    input  logic             i_presetn,
    input  logic             i_psel,
    input  logic             i_penable,
    input  logic             i_pwrite,
    input  logic [ASIZE-1:0] i_paddr,
    input  logic [DSIZE-1:0] i_pwdata,
    output logic [DSIZE-1:0] o_prdata,
    output logic             o_pready,
    output logic             o_pslverr
);

    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StAccess = 1'b1;

    logic [0:0]       r_state;
    logic [3:0]       r_wait_cnt;
    logic [ASIZE-1:0] r_addr;
    logic [DSIZE-1:0] r_wdata;
    logic             r_write;
    logic [DSIZE-1:0] r_regs [NUM_REGS];

    logic [0:0]       w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic             w_capture;
    logic             w_pready;
    logic [ASIZE-1:0] w_off;
    logic [ASIZE-1:0] w_word;
    logic [IDXW-1:0]  w_idx;
    logic             w_err;
    logic             w_wr_en;
    logic [DSIZE-1:0] w_rdata;

    // Completion is decoded from registered state plus the live strobes.
    assign w_pready = (r_state == StAccess) && i_psel && i_penable && (r_wait_cnt == 4'd0);

    // Decode works only on the captured address so mid-access PADDR changes are harmless.
    assign w_off  = r_addr - BASE_ADDR;
    assign w_word = w_off >> 2;
    assign w_idx  = w_word[IDXW-1:0];
    assign w_err  = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR) ||
                    (w_word >= ASIZE'(NUM_REGS)) || (r_write && (w_word == '0));

    assign w_wr_en = w_pready && r_write && !w_err;
    assign w_rdata = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];

    assign o_pready  = w_pready;
    assign o_pslverr = w_pready && w_err;
    assign o_prdata  = (w_pready && !r_write && !w_err) ? w_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_capture   = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt = StAccess;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_capture   = 1'b1;
                end
            end
            StAccess: begin
                if (!i_psel) begin
                    w_state_nxt = StIdle;
                end else if (i_penable) begin
                    if (r_wait_cnt != 4'd0) begin
                        w_cnt_nxt = r_wait_cnt - 4'd1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state    <= StIdle;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            if (w_capture) begin
                r_addr  <= i_paddr;
                r_wdata <= i_pwdata;
                r_write <= i_pwrite;
            end
        end
    end

    // Entry 0 is never written; its read value comes from ID_VALUE.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_en && (w_idx == IDXW'(i))) begin
                    r_regs[i] <= r_wdata;
                end
            end
        end
    end

endmodule
